// File: rtl/multicycle_controller.sv
// multicycle_controller: RISC-V multicycle control FSM with shared-memory handshake,
// sticky illegal-opcode trap and retired-instruction counter.
module multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ImmSrc,
    output logic [2:0]       ALUControl,
    output logic             Illegal,
    output logic [CNT_W-1:0] InstRet
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, ALUWB, EXECI, JAL, BEQ, TRAP
    } state_t;

    state_t           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [1:0]       alu_op;
    logic             pc_update, branch, ir_write, mem_write, reg_write;

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:    state_d = MemReady ? DECODE : FETCH;
            DECODE:   state_d = (op == 7'b0000011 || op == 7'b0100011) ? MEMADR :
                                (op == 7'b0110011) ? EXECR :
                                (op == 7'b0010011) ? EXECI :
                                (op == 7'b1101111) ? JAL :
                                (op == 7'b1100011) ? BEQ : TRAP;
            MEMADR:   state_d = (op == 7'b0000011) ? MEMREAD : MEMWRITE;
            MEMREAD:  state_d = MemReady ? MEMWB : MEMREAD;
            MEMWRITE: state_d = MemReady ? FETCH : MEMWRITE;
            EXECR, EXECI, JAL: state_d = ALUWB;
            MEMWB, ALUWB, BEQ: state_d = FETCH;
            TRAP:     state_d = TRAP;
            default:  state_d = FETCH;
        endcase
        illegal_d = illegal_q | (state_d == TRAP);
        // A retirement is any return to FETCH from a working state.
        instret_d = (state_d == FETCH && state_q != FETCH && state_q != TRAP)
                    ? instret_q + CNT_W'(1) : instret_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        alu_op    = 2'b00;
        pc_update = 1'b0;
        branch    = 1'b0;
        ir_write  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        case (state_q)
            FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                ir_write  = MemReady;
                pc_update = MemReady;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD:  AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                reg_write = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
            end
            EXECR: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
            end
            EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
            end
            ALUWB:    reg_write = 1'b1;
            JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                branch  = 1'b1;
            end
            default: ;
        endcase
    end

    // Write enables are gated by reset so nothing commits while it is held low.
    assign PCWrite  = reset & (pc_update | (branch & Zero));
    assign IRWrite  = reset & ir_write;
    assign MemWrite = reset & mem_write;
    assign RegWrite = reset & reg_write;

    assign ImmSrc = (op == 7'b0100011) ? 2'b01 :
                    (op == 7'b1100011) ? 2'b10 :
                    (op == 7'b1101111) ? 2'b11 : 2'b00;

    assign ALUControl = (alu_op == 2'b00) ? 3'b000 :
                        (alu_op == 2'b01) ? 3'b001 :
                        (funct3 == 3'b000) ? {2'b00, op[5] & funct7b5} :
                        (funct3 == 3'b010) ? 3'b101 :
                        (funct3 == 3'b110) ? 3'b011 :
                        (funct3 == 3'b111) ? 3'b010 : 3'b000;

    assign Illegal = illegal_q;
    assign InstRet = instret_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed cycle-by-cycle checks of the control outputs,
// with a second 2-bit-counter instance to exercise InstRet wrap-around.
module tb_multicycle_controller;
    logic        clk = 1'b0, reset = 1'b0;
    logic [6:0]  op = 7'b0110011;
    logic [2:0]  funct3 = 3'b000;
    logic        funct7b5 = 1'b0, Zero = 1'b0, MemReady = 1'b1;
    logic        PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, Illegal;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0]  ALUControl;
    logic [31:0] InstRet;
    logic        PCWrite2, AdrSrc2, IRWrite2, MemWrite2, RegWrite2, Illegal2;
    logic [1:0]  ResultSrc2, ALUSrcA2, ALUSrcB2, ImmSrc2;
    logic [2:0]  ALUControl2;
    logic [1:0]  InstRet2;
    logic [16:0] obs, obs2;
    int          checks = 0, failures = 0;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .Illegal(Illegal), .InstRet(InstRet)
    );

    multicycle_controller #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite2), .AdrSrc(AdrSrc2),
        .IRWrite(IRWrite2), .MemWrite(MemWrite2), .RegWrite(RegWrite2),
        .ResultSrc(ResultSrc2), .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2), .ImmSrc(ImmSrc2),
        .ALUControl(ALUControl2), .Illegal(Illegal2), .InstRet(InstRet2)
    );

    // Packed as pcw adr irw mw rw | rs | sa | sb | imm | alu | ill
    assign obs  = {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc, ALUSrcA,
                   ALUSrcB, ImmSrc, ALUControl, Illegal};
    assign obs2 = {PCWrite2, AdrSrc2, IRWrite2, MemWrite2, RegWrite2, ResultSrc2, ALUSrcA2,
                   ALUSrcB2, ImmSrc2, ALUControl2, Illegal2};

    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [16:0] e);
        #1;
        checks++;
        assert ({obs, obs2} === {e, e}) else begin
            failures++;
            $error("FAIL %s: observed %b / %b expected %b", tag, obs, obs2, e);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] e, input logic [1:0] e2);
        #1;
        checks++;
        assert (InstRet === e && InstRet2 === e2) else begin
            failures++;
            $error("FAIL %s: observed InstRet %0d / %0d expected %0d / %0d", tag, InstRet, InstRet2, e, e2);
        end
    endtask

    task automatic alu_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic [16:0] ex);
        op = o; funct3 = f3; funct7b5 = f7;
        chk({tag, "_fetch"}, 17'b1_0_1_0_0_10_00_10_00_000_0);
        cyc;
        chk({tag, "_decode"}, 17'b0_0_0_0_0_00_01_01_00_000_0);
        cyc;
        chk({tag, "_exec"}, ex);
        cyc;
        chk({tag, "_aluwb"}, 17'b0_0_0_0_1_00_00_00_00_000_0);
        cyc;
    endtask

    initial begin
        cyc;
        chk("reset_fetch", 17'b0_0_0_0_0_10_00_10_00_000_0);
        chk_cnt("reset_cnt", 0, 0);
        cyc;
        reset = 1'b1;
        alu_instr("add", 7'b0110011, 3'b000, 1'b0, 17'b0_0_0_0_0_00_10_00_00_000_0);
        chk_cnt("add_cnt", 1, 1);
        alu_instr("sub", 7'b0110011, 3'b000, 1'b1, 17'b0_0_0_0_0_00_10_00_00_001_0);
        chk_cnt("sub_cnt", 2, 2);
        alu_instr("addi_b30", 7'b0010011, 3'b000, 1'b1, 17'b0_0_0_0_0_00_10_01_00_000_0);
        chk_cnt("addi_cnt", 3, 3);
        alu_instr("slti", 7'b0010011, 3'b010, 1'b0, 17'b0_0_0_0_0_00_10_01_00_101_0);
        chk_cnt("slti_cnt_wrap", 4, 0);
        alu_instr("or", 7'b0110011, 3'b110, 1'b0, 17'b0_0_0_0_0_00_10_00_00_011_0);
        chk_cnt("or_cnt", 5, 1);
        alu_instr("andi", 7'b0010011, 3'b111, 1'b0, 17'b0_0_0_0_0_00_10_01_00_010_0);
        chk_cnt("andi_cnt", 6, 2);
        alu_instr("f3_001", 7'b0110011, 3'b001, 1'b1, 17'b0_0_0_0_0_00_10_00_00_000_0);
        chk_cnt("f3_001_cnt", 7, 3);

        op = 7'b0000011; funct3 = 3'b010; MemReady = 1'b0;
        chk("lw_fetch_stall", 17'b0_0_0_0_0_10_00_10_00_000_0);
        cyc; MemReady = 1'b1;
        chk("lw_fetch", 17'b1_0_1_0_0_10_00_10_00_000_0);
        cyc; MemReady = 1'b0;
        chk("lw_decode", 17'b0_0_0_0_0_00_01_01_00_000_0);
        cyc;
        chk("lw_memadr", 17'b0_0_0_0_0_00_10_01_00_000_0);
        cyc;
        chk("lw_memread0", 17'b0_1_0_0_0_00_00_00_00_000_0);
        cyc;
        chk("lw_memread1", 17'b0_1_0_0_0_00_00_00_00_000_0);
        cyc;
        chk("lw_memread2", 17'b0_1_0_0_0_00_00_00_00_000_0);
        cyc; MemReady = 1'b1;
        chk("lw_memread3", 17'b0_1_0_0_0_00_00_00_00_000_0);
        cyc;
        chk("lw_memwb", 17'b0_0_0_0_1_01_00_00_00_000_0);
        cyc;
        chk_cnt("lw_cnt", 8, 0);

        op = 7'b1100011; funct3 = 3'b000; Zero = 1'b1;
        chk("beq1_fetch", 17'b1_0_1_0_0_10_00_10_10_000_0);
        cyc;
        chk("beq1_decode", 17'b0_0_0_0_0_00_01_01_10_000_0);
        cyc;
        chk("beq1_taken", 17'b1_0_0_0_0_00_10_00_10_001_0);
        cyc;
        chk_cnt("beq1_cnt", 9, 1);
        Zero = 1'b0;
        chk("beq0_fetch", 17'b1_0_1_0_0_10_00_10_10_000_0);
        cyc; cyc;
        chk("beq0_not_taken", 17'b0_0_0_0_0_00_10_00_10_001_0);
        cyc;
        chk_cnt("beq0_cnt", 10, 2);

        op = 7'b1101111;
        chk("jal_fetch", 17'b1_0_1_0_0_10_00_10_11_000_0);
        cyc;
        chk("jal_decode", 17'b0_0_0_0_0_00_01_01_11_000_0);
        cyc;
        chk("jal_jal", 17'b1_0_0_0_0_00_01_10_11_000_0);
        cyc;
        chk("jal_aluwb", 17'b0_0_0_0_1_00_00_00_11_000_0);
        cyc;
        chk_cnt("jal_cnt", 11, 3);

        op = 7'b0100011;
        chk("sw_fetch", 17'b1_0_1_0_0_10_00_10_01_000_0);
        cyc; cyc;
        chk("sw_memadr", 17'b0_0_0_0_0_00_10_01_01_000_0);
        cyc;
        chk("sw_memwrite", 17'b0_1_0_1_0_00_00_00_01_000_0);
        cyc;
        chk_cnt("sw_cnt", 12, 0);

        cyc; cyc; cyc; MemReady = 1'b0;
        chk("sw_wait0", 17'b0_1_0_1_0_00_00_00_01_000_0);
        cyc;
        chk("sw_wait1", 17'b0_1_0_1_0_00_00_00_01_000_0);
        reset = 1'b0;
        chk("sw_reset_now", 17'b0_1_0_0_0_00_00_00_01_000_0);
        cyc;
        chk("sw_reset_fetch", 17'b0_0_0_0_0_10_00_10_01_000_0);
        chk_cnt("sw_reset_cnt", 0, 0);

        cyc; reset = 1'b1; MemReady = 1'b1; op = 7'b1111111;
        chk("trap_fetch", 17'b1_0_1_0_0_10_00_10_00_000_0);
        cyc;
        chk("trap_decode", 17'b0_0_0_0_0_00_01_01_00_000_0);
        cyc; Zero = 1'b1;
        for (int i = 0; i < 10; i++) begin
            MemReady = i[0];
            chk("trap_hold", 17'b0_0_0_0_0_00_00_00_00_000_1);
            cyc;
        end
        chk_cnt("trap_cnt", 0, 0);
        reset = 1'b0; MemReady = 1'b1;
        chk("trap_reset_now", 17'b0_0_0_0_0_00_00_00_00_000_1);
        cyc;
        chk("trap_reset_fetch", 17'b0_0_0_0_0_10_00_10_00_000_0);
        chk_cnt("trap_reset_cnt", 0, 0);
        cyc; reset = 1'b1; Zero = 1'b0;
        alu_instr("post_trap_add", 7'b0110011, 3'b000, 1'b0, 17'b0_0_0_0_0_00_10_00_00_000_0);
        chk_cnt("post_trap_cnt", 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter: CNT_W, 32, width of retired-instruction counter.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-low; sampled on rising clk.
REQ-004 op  in  7  instruction opcode.
REQ-005 funct3  in  3  instruction funct3.
REQ-006 funct7b5  in  1  instruction bit 30.
REQ-007 Zero  in  1  ALU zero flag.
REQ-008 MemReady  in  1  shared memory has completed the current access.
REQ-009 PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite  out  1 each  datapath enables and selects.
REQ-010 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  out  2 each  mux selects and immediate format.
REQ-011 ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-012 Illegal  out  1  sticky unsupported-opcode flag.
REQ-013 InstRet  out  CNT_W  retired-instruction count.

Function
REQ-014 FSM states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, ALUWB, EXECI, JAL, BEQ, TRAP.
REQ-015 Outputs not listed for a state SHALL be 0.
REQ-016 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite=1 and PCUpdate=1 only when MemReady=1. Stays in FETCH while MemReady=0, else goes to DECODE.
REQ-017 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
- op 0000011 or 0100011 -> MEMADR.
- 0110011 -> EXECR.
- 0010011 -> EXECI.
- 1101111 -> JAL.
- 1100011 -> BEQ.
- any other op -> TRAP.
REQ-018 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. op 0000011 -> MEMREAD, else -> MEMWRITE.
REQ-019 MEMREAD: ResultSrc=00, AdrSrc=1. Holds while MemReady=0, else -> MEMWB.
REQ-020 MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
REQ-021 MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1 held until MemReady=1, then -> FETCH.
REQ-022 EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
REQ-023 EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
REQ-024 ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
REQ-025 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 -> ALUWB.
REQ-026 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1 -> FETCH.
REQ-027 TRAP: all enables 0, Illegal=1. Remains in TRAP until reset.
REQ-028 PCWrite = PCUpdate | (Branch & Zero); combinational in the current cycle.
REQ-029 ImmSrc decoded from op in every state:
- 0100011 -> 01
- 1100011 -> 10
- 1101111 -> 11
- otherwise -> 00
REQ-030 ALU decode:
- ALUOp 00 -> add; ALUOp 01 -> sub.
- ALUOp 10 with funct3 000: sub when op[5]&funct7b5, else add.
- funct3 010 -> slt; 110 -> or; 111 -> and; any other funct3 -> add.
REQ-031 InstRet SHALL increment by 1, modulo 2^CNT_W, on each transition from a non-FETCH, non-TRAP state into FETCH. It wraps to 0 from all-ones.
REQ-032 Latency with MemReady held 1, in cycles from FETCH entry to the next FETCH entry: lw 5, sw 4, R/I-ALU 4, jal 4, beq 3.
REQ-033 MemReady SHALL be ignored in every state except FETCH, MEMREAD and MEMWRITE.

Reset
REQ-034 When reset=0 at a rising edge: state=FETCH, InstRet=0, Illegal=0. This includes reset mid-instruction and reset while in TRAP.
REQ-035 While reset=0, PCWrite, IRWrite, MemWrite and RegWrite SHALL be forced to 0.
REQ-036 The first fetch occurs in the first cycle after reset is sampled 1.

Verification
REQ-037 Scenario 1: reset, then R-type add (op 0110011, funct3 000, funct7b5 0), MemReady=1.
- Expect states FETCH, DECODE, EXECR, ALUWB; ALUControl=000 in EXECR; RegWrite=1 only in ALUWB; InstRet=1.
REQ-038 Scenario 2: lw (op 0000011) with MemReady=0 for 3 cycles in MEMREAD.
- Expect MEMREAD held 4 cycles with AdrSrc=1, then MEMWB with ResultSrc=01 and RegWrite=1; 8 cycles total.
REQ-039 Scenario 3: beq (op 1100011).
- Zero=1: expect PCWrite=1 in BEQ with ALUControl=001 and ImmSrc=10.
- Zero=0: expect PCWrite=0.
- Both cases: InstRet increments.
REQ-040 Scenario 4: jal (op 1101111).
- Expect PCWrite=1 in JAL, then ALUWB with RegWrite=1; ImmSrc=11; 4 cycles.
REQ-041 Scenario 5: op 1111111.
- Expect TRAP, Illegal=1, all enables 0 for 10 cycles; reset=0 returns to FETCH with Illegal=0.
REQ-042 Scenario 6: reset=0 asserted in MEMWRITE while MemReady=0.
- Expect MemWrite=0 immediately, FETCH next cycle, InstRet=0; also preload InstRet to all-ones and confirm it wraps to 0.
